// File: rtl/route_lookup_ctrl_if.sv
// route_lookup_ctrl_if: bundles the packet stream, the CAM lookup port and the
// routing-result handshake of route_lookup_ctrl into one interface.
// The slave modport is the controller's view; master is the surrounding logic.
interface route_lookup_ctrl_if #(
    parameter int KEYLEN   = 32,
    parameter int ADDRBITS = 9,
    parameter int LENW     = 12
);
    // Packet word stream
    logic [KEYLEN-1:0]   s_tdata;
    logic                s_tvalid;
    logic                s_tlast;
    logic                s_tready;

    // CAM lookup port
    logic                cam_match_en;
    logic [KEYLEN-1:0]   cam_data_in;
    logic                cam_match;
    logic [ADDRBITS-1:0] cam_match_addr;

    // Routing result handshake
    logic                r_valid;
    logic                r_ready;
    logic                r_hit;
    logic [ADDRBITS-1:0] r_index;
    logic                r_short;
    logic [LENW-1:0]     r_len;

    modport master (
        output s_tdata, s_tvalid, s_tlast, cam_match, cam_match_addr, r_ready,
        input  s_tready, cam_match_en, cam_data_in,
               r_valid, r_hit, r_index, r_short, r_len
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, cam_match, cam_match_addr, r_ready,
        output s_tready, cam_match_en, cam_data_in,
               r_valid, r_hit, r_index, r_short, r_len
    );
endinterface

// File: rtl/route_lookup_ctrl.sv
// route_lookup_ctrl: front end of the lookup pipeline. Takes the packet word
// stream, pulls the destination key out of word HDR_WORD, fires one CAM match
// per packet, waits LOOKUP_LAT cycles for the answer and offers a per-packet
// result (hit, 0-based index, short flag, saturated length) on a valid/ready
// handshake. One packet is in flight at a time.
// Optional feature: define DEFAULT_ROUTE_EN to report DEFAULT_INDEX instead of
// 0 as the index of a miss or short packet.
module route_lookup_ctrl #(
    parameter int KEYLEN        = 32,
    parameter int ADDRBITS      = 9,
    parameter int HDR_WORD      = 0,
    parameter int LOOKUP_LAT    = 1,   // 1..7
    parameter int LENW          = 12,
    parameter int DEFAULT_INDEX = 0
) (
    input  logic               clk,
    input  logic               resetn,
    route_lookup_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RX     = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    localparam logic [LENW-1:0] LEN_MAX = '1;

`ifdef DEFAULT_ROUTE_EN
    localparam bit DEFAULT_ROUTE = 1'b1;
`else
    localparam bit DEFAULT_ROUTE = 1'b0;
`endif
    // Index reported when no CAM entry applies (miss or short packet).
    localparam logic [ADDRBITS-1:0] MISS_INDEX =
        ADDRBITS'(DEFAULT_INDEX) & {ADDRBITS{DEFAULT_ROUTE}};

    logic [1:0]          state_q,    state_d;
    logic [LENW-1:0]     wcnt_q,     wcnt_d;
    logic                have_key_q, have_key_d;
    logic [KEYLEN-1:0]   key_q,      key_d;
    logic [2:0]          lat_q,      lat_d;
    logic                hit_q,      hit_d;
    logic [ADDRBITS-1:0] index_q,    index_d;
    logic                short_q,    short_d;
    logic [LENW-1:0]     len_q,      len_d;

    logic                rx_ready;
    logic                accept;
    logic                hdr_now;
    logic [LENW-1:0]     wcnt_inc;

    // s_tready is forced low while resetn is asserted so every output reads 0
    // in reset, yet it is high in the very first cycle after release.
    assign rx_ready = resetn && (state_q == ST_RX);
    assign accept   = bus.s_tvalid && rx_ready;
    assign wcnt_inc = (wcnt_q == LEN_MAX) ? LEN_MAX : wcnt_q + LENW'(1);
    // have_key guard stops a saturated counter from re-capturing the key.
    assign hdr_now  = !have_key_q && (32'(wcnt_q) == HDR_WORD);

    // Next-state and datapath update of the packet/lookup/result sequence.
    always_comb begin
        // NOTE: every _d starts at its hold value so no branch of the case can infer a latch.
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        have_key_d = have_key_q;
        key_d      = key_q;
        lat_d      = lat_q;
        hit_d      = hit_q;
        index_d    = index_q;
        short_d    = short_q;
        len_d      = len_q;

        case (state_q)
            ST_RX: begin
                if (accept) begin
                    wcnt_d = wcnt_inc;
                    if (hdr_now) begin
                        key_d      = bus.s_tdata;
                        have_key_d = 1'b1;
                    end
                    if (bus.s_tlast) begin
                        len_d = wcnt_inc;
                        if (have_key_q || hdr_now) begin
                            state_d = ST_LOOKUP;
                        end else begin
                            // Packet ended before the key word: no lookup.
                            short_d = 1'b1;
                            hit_d   = 1'b0;
                            index_d = MISS_INDEX;
                            state_d = ST_RESULT;
                        end
                    end
                end
            end

            ST_LOOKUP: begin
                lat_d   = 3'(LOOKUP_LAT);
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                lat_d = lat_q - 3'd1;
                // Counter reaches 0 on this edge: the CAM answer is valid now.
                if (lat_q == 3'd1) begin
                    hit_d   = bus.cam_match;
                    index_d = bus.cam_match ? bus.cam_match_addr - ADDRBITS'(1)
                                            : MISS_INDEX;
                    state_d = ST_RESULT;
                end
            end

            ST_RESULT: begin
                if (bus.r_ready) begin
                    wcnt_d     = '0;
                    have_key_d = 1'b0;
                    short_d    = 1'b0;
                    state_d    = ST_RX;
                end
            end

            default: state_d = ST_RX;
        endcase
    end

    // State and datapath registers, cleared asynchronously by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RX;
            wcnt_q     <= '0;
            have_key_q <= 1'b0;
            key_q      <= '0;
            lat_q      <= '0;
            hit_q      <= 1'b0;
            index_q    <= '0;
            short_q    <= 1'b0;
            len_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            have_key_q <= have_key_d;
            key_q      <= key_d;
            lat_q      <= lat_d;
            hit_q      <= hit_d;
            index_q    <= index_d;
            short_q    <= short_d;
            len_q      <= len_d;
        end
    end

    assign bus.s_tready     = rx_ready;
    assign bus.cam_match_en = (state_q == ST_LOOKUP);
    assign bus.cam_data_in  = key_q;
    assign bus.r_valid      = (state_q == ST_RESULT);
    assign bus.r_hit        = hit_q;
    assign bus.r_index      = index_q;
    assign bus.r_short      = short_q;
    assign bus.r_len        = len_q;

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// tb_route_lookup_ctrl: two controller instances (A: key in word 0, latency 1,
// 12-bit length; B: key in word 2, latency 3, 4-bit length) driven through
// their interfaces, each with a CAM model that presents its answer only in the
// single cycle the controller is supposed to sample it.
module tb_route_lookup_ctrl;

    localparam int LENW_A = 12;
    localparam int LENW_B = 4;
    localparam int HDR_A  = 0;
    localparam int HDR_B  = 2;
    localparam int LAT_A  = 1;
    localparam int LAT_B  = 3;
    localparam int DEF_IX = 3;
`ifdef DEFAULT_ROUTE_EN
    localparam int MISS_IX = DEF_IX;
`else
    localparam int MISS_IX = 0;
`endif

    typedef struct packed {
        logic       hit;
        logic [8:0] addr;
    } cam_t;

    typedef struct packed {
        logic        hit;
        logic [8:0]  idx;
        logic        sh;
        logic [11:0] len;
    } res_t;

    typedef struct {
        int          d;
        int          len;
        logic [31:0] key;
        logic        e_hit;
        logic [8:0]  e_idx;
        logic        e_short;
        logic [11:0] e_len;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus and observation arrays, index 0 = instance A, 1 = instance B.
    logic [31:0] s_tdata  [2];
    logic        s_tvalid [2];
    logic        s_tlast  [2];
    logic        r_ready  [2];
    logic        o_tready [2];
    logic        o_en     [2];
    logic [31:0] o_cdata  [2];
    logic        o_valid  [2];
    logic        o_hit    [2];
    logic [8:0]  o_index  [2];
    logic        o_short  [2];
    logic [11:0] o_len    [2];
    cam_t        cam_now  [2];

    route_lookup_ctrl_if #(.KEYLEN(32), .ADDRBITS(9), .LENW(LENW_A)) bus_a ();
    route_lookup_ctrl_if #(.KEYLEN(32), .ADDRBITS(9), .LENW(LENW_B)) bus_b ();

    route_lookup_ctrl #(
        .KEYLEN(32), .ADDRBITS(9), .HDR_WORD(HDR_A), .LOOKUP_LAT(LAT_A),
        .LENW(LENW_A), .DEFAULT_INDEX(DEF_IX)
    ) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));

    route_lookup_ctrl #(
        .KEYLEN(32), .ADDRBITS(9), .HDR_WORD(HDR_B), .LOOKUP_LAT(LAT_B),
        .LENW(LENW_B), .DEFAULT_INDEX(DEF_IX)
    ) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    assign bus_a.s_tdata        = s_tdata[0];
    assign bus_a.s_tvalid       = s_tvalid[0];
    assign bus_a.s_tlast        = s_tlast[0];
    assign bus_a.r_ready        = r_ready[0];
    assign bus_a.cam_match      = cam_now[0].hit;
    assign bus_a.cam_match_addr = cam_now[0].addr;
    assign bus_b.s_tdata        = s_tdata[1];
    assign bus_b.s_tvalid       = s_tvalid[1];
    assign bus_b.s_tlast        = s_tlast[1];
    assign bus_b.r_ready        = r_ready[1];
    assign bus_b.cam_match      = cam_now[1].hit;
    assign bus_b.cam_match_addr = cam_now[1].addr;

    assign o_tready[0] = bus_a.s_tready;
    assign o_en[0]     = bus_a.cam_match_en;
    assign o_cdata[0]  = bus_a.cam_data_in;
    assign o_valid[0]  = bus_a.r_valid;
    assign o_hit[0]    = bus_a.r_hit;
    assign o_index[0]  = bus_a.r_index;
    assign o_short[0]  = bus_a.r_short;
    assign o_len[0]    = 12'(bus_a.r_len);
    assign o_tready[1] = bus_b.s_tready;
    assign o_en[1]     = bus_b.cam_match_en;
    assign o_cdata[1]  = bus_b.cam_data_in;
    assign o_valid[1]  = bus_b.r_valid;
    assign o_hit[1]    = bus_b.r_hit;
    assign o_index[1]  = bus_b.r_index;
    assign o_short[1]  = bus_b.r_short;
    assign o_len[1]    = 12'(bus_b.r_len);

    // CAM contents: key -> 1-based position.
    function automatic cam_t cam_ref(input logic [31:0] k);
        cam_t c;
        case (k)
            32'h0A0B0C0D: c = '{1'b1, 9'd6};
            32'h11111111: c = '{1'b1, 9'd1};
            32'hCAFEF00D: c = '{1'b1, 9'd511};
            32'h12345678: c = '{1'b1, 9'd42};
            32'h0BADF00D: c = '{1'b1, 9'd100};
            32'h5A5A5A5A: c = '{1'b1, 9'd7};
            default:      c = '{1'b0, 9'd0};
        endcase
        return c;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    // CAM model: records each match strobe and counts down the latency.
    int          cd       [2] = '{0, 0};
    int          en_cnt   [2] = '{0, 0};
    int          en_cyc   [2] = '{0, 0};
    logic [31:0] seen_key [2] = '{32'h0, 32'h0};

    always @(posedge clk or negedge resetn) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                cd[d] <= 0;
            end else if (o_en[d]) begin
                cd[d]       <= lat_of(d);
                en_cnt[d]   <= en_cnt[d] + 1;
                en_cyc[d]   <= cyc;
                seen_key[d] <= o_cdata[d];
            end else if (cd[d] > 0) begin
                cd[d] <= cd[d] - 1;
            end
        end
    end

    // The true answer is visible only in the sampling cycle; otherwise the
    // model shows an inverted answer so early or late sampling is caught.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            cam_now[d] = cam_ref(seen_key[d]);
            if (cd[d] != 1) begin
                cam_now[d].hit  = ~cam_now[d].hit;
                cam_now[d].addr = ~cam_now[d].addr;
            end
        end
    end

    // Reference result of one packet, derived directly from the routing rules.
    function automatic res_t model(input int d, input int len, input logic [31:0] key);
        res_t r;
        cam_t c;
        int   hdr;
        int   lmax;
        hdr   = (d == 0) ? HDR_A : HDR_B;
        lmax  = (d == 0) ? (1 << LENW_A) - 1 : (1 << LENW_B) - 1;
        r.len = 12'((len > lmax) ? lmax : len);
        if (len <= hdr) begin
            r.sh  = 1'b1;
            r.hit = 1'b0;
            r.idx = 9'(MISS_IX);
        end else begin
            c     = cam_ref(key);
            r.sh  = 1'b0;
            r.hit = c.hit;
            r.idx = c.hit ? 9'(int'(c.addr) - 1) : 9'(MISS_IX);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_tready"}, o_tready[d], 1'b0);
        check({tag, "_match_en"}, o_en[d], 1'b0);
        check({tag, "_cam_data"}, o_cdata[d], 32'h0);
        check({tag, "_r_valid"}, o_valid[d], 1'b0);
        check({tag, "_r_hit"}, o_hit[d], 1'b0);
        check({tag, "_r_index"}, o_index[d], 9'h0);
        check({tag, "_r_short"}, o_short[d], 1'b0);
        check({tag, "_r_len"}, o_len[d], 12'h0);
    endtask

    // Send one packet; the key goes in the instance's header word.
    task automatic send_pkt(input int d, input int len, input logic [31:0] key, input bit gaps);
        int hdr;
        int guard;
        hdr = (d == 0) ? HDR_A : HDR_B;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    s_tvalid[d] = 1'b0;
                    s_tlast[d]  = 1'b0;
                end
            end
            @(negedge clk);
            s_tdata[d]  = (i == hdr) ? key : $urandom;
            s_tvalid[d] = 1'b1;
            s_tlast[d]  = (i == len - 1);
            guard = 0;
            while (!o_tready[d] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!o_tready[d]) begin
                check("tready_timeout", o_tready[d], 1'b1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
    endtask

    // Wait for the result, hold it for 'hold' cycles, then accept it.
    task automatic get_result(input int d, input int hold, output res_t r, output int lat);
        int guard;
        guard = 0;
        while (!o_valid[d] && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!o_valid[d]) check("result_timeout", o_valid[d], 1'b1);
        lat   = cyc - en_cyc[d] - 1;
        r.hit = o_hit[d];
        r.idx = o_index[d];
        r.sh  = o_short[d];
        r.len = o_len[d];
        repeat (hold) @(negedge clk);
        r_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        r_ready[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_one(input int d, input int len, input logic [31:0] key,
                           input bit gaps, input int hold,
                           output res_t r, output int lat, output int pulses);
        int en0;
        en0 = en_cnt[d];
        send_pkt(d, len, key, gaps);
        get_result(d, hold, r, lat);
        pulses = en_cnt[d] - en0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

    initial begin
        vec_t        vec [11];
        res_t        r;
        res_t        e;
        res_t        held;
        int          lat;
        int          pulses;
        int          d;
        int          len;
        logic [31:0] key;
        logic [31:0] known [6];

        known = '{32'h0A0B0C0D, 32'h11111111, 32'hCAFEF00D,
                  32'h12345678, 32'h0BADF00D, 32'h5A5A5A5A};

        vec[0]  = '{0, 4,  32'h0A0B0C0D, 1'b1, 9'd5,          1'b0, 12'd4};
        vec[1]  = '{0, 1,  32'h11111111, 1'b1, 9'd0,          1'b0, 12'd1};
        vec[2]  = '{0, 3,  32'hDEADBEEF, 1'b0, 9'(MISS_IX),   1'b0, 12'd3};
        vec[3]  = '{0, 2,  32'hCAFEF00D, 1'b1, 9'd510,        1'b0, 12'd2};
        vec[4]  = '{1, 2,  32'h0,        1'b0, 9'(MISS_IX),   1'b1, 12'd2};
        vec[5]  = '{1, 1,  32'h0,        1'b0, 9'(MISS_IX),   1'b1, 12'd1};
        vec[6]  = '{1, 3,  32'h12345678, 1'b1, 9'd41,         1'b0, 12'd3};
        vec[7]  = '{1, 20, 32'h0BADF00D, 1'b1, 9'd99,         1'b0, 12'd15};
        vec[8]  = '{1, 15, 32'h5A5A5A5A, 1'b1, 9'd6,          1'b0, 12'd15};
        vec[9]  = '{1, 16, 32'hDEADBEEF, 1'b0, 9'(MISS_IX),   1'b0, 12'd15};
        vec[10] = '{1, 5,  32'h0A0B0C0D, 1'b1, 9'd5,          1'b0, 12'd5};

        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            r_ready[i]  = 1'b0;
        end

        // Reset state
        #1;
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_rel_tready_a", o_tready[0], 1'b1);
        check("rst_rel_tready_b", o_tready[1], 1'b1);
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            run_one(vec[i].d, vec[i].len, vec[i].key, 1'b0, 0, r, lat, pulses);
            check($sformatf("v%0d_hit", i), r.hit, vec[i].e_hit);
            check($sformatf("v%0d_index", i), r.idx, vec[i].e_idx);
            check($sformatf("v%0d_short", i), r.sh, vec[i].e_short);
            check($sformatf("v%0d_len", i), r.len, vec[i].e_len);
            check($sformatf("v%0d_pulses", i), pulses, vec[i].e_short ? 0 : 1);
            if (!vec[i].e_short) begin
                check($sformatf("v%0d_cam_key", i), seen_key[vec[i].d], vec[i].key);
                check($sformatf("v%0d_latency", i), lat, lat_of(vec[i].d));
            end
        end

        // Backpressure on A: result held 10 cycles while the next word waits.
        send_pkt(0, 4, 32'h0A0B0C0D, 1'b0);
        get_result(0, 0, held, lat);  // discards: re-run below with manual hold
        send_pkt(0, 4, 32'h0A0B0C0D, 1'b0);
        begin
            int guard;
            guard = 0;
            while (!o_valid[0] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        check("bp_valid", o_valid[0], 1'b1);
        held = '{o_hit[0], o_index[0], o_short[0], o_len[0]};
        check("bp_fields", held, {1'b1, 9'd5, 1'b0, 12'd4});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_tdata[0]  = 32'hDEADBEEF;
            s_tvalid[0] = 1'b1;
            s_tlast[0]  = 1'b1;
            check($sformatf("bp%0d_valid", k), o_valid[0], 1'b1);
            check($sformatf("bp%0d_tready", k), o_tready[0], 1'b0);
            check($sformatf("bp%0d_stable", k),
                  {o_hit[0], o_index[0], o_short[0], o_len[0]}, held);
        end
        r_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        r_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_after_valid", o_valid[0], 1'b0);
        check("bp_after_tready", o_tready[0], 1'b1);
        @(posedge clk);
        #1;
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        @(negedge clk);
        get_result(0, 0, r, lat);
        check("bp_next_hit", r.hit, 1'b0);
        check("bp_next_index", r.idx, 9'(MISS_IX));
        check("bp_next_len", r.len, 12'd1);

        // Reset while B waits for the CAM answer.
        send_pkt(1, 3, 32'h12345678, 1'b0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_zero(1, "rst_wait_b");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_wait_rel_tready", o_tready[1], 1'b1);
        @(negedge clk);
        run_one(1, 4, 32'h5A5A5A5A, 1'b0, 0, r, lat, pulses);
        check("rst_recover", r, {1'b1, 9'd6, 1'b0, 12'd4});
        check("rst_recover_pulses", pulses, 1);

        // Randomized packets against the reference model.
        for (int n = 0; n < 40; n++) begin
            d   = $urandom_range(0, 1);
            len = (d == 0) ? $urandom_range(1, 8) : $urandom_range(1, 20);
            key = ($urandom_range(0, 1) == 1) ? known[$urandom_range(0, 5)] : $urandom;
            e   = model(d, len, key);
            run_one(d, len, key, 1'b1, $urandom_range(0, 3), r, lat, pulses);
            check($sformatf("rnd%0d_hit", n), r.hit, e.hit);
            check($sformatf("rnd%0d_index", n), r.idx, e.idx);
            check($sformatf("rnd%0d_short", n), r.sh, e.sh);
            check($sformatf("rnd%0d_len", n), r.len, e.len);
            check($sformatf("rnd%0d_pulses", n), pulses, e.sh ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
